// File: rtl/counter_seq_pkg.sv
// Shared types for the counter command sequencer: command opcodes and FSM states.
package counter_seq_pkg;

    typedef enum logic [1:0] {OP_LOAD, OP_UP, OP_DOWN, OP_HOLD} cmd_op_e;
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HOLD} seq_state_e;

endpackage

// File: rtl/counter_cmd_sequencer.sv
// Command sequencer ahead of an 8-bit up/down counter: turns LOAD/UP/DOWN/HOLD
// commands into registered ld_en/en/updwn/datain strobes and reports completion.
module counter_cmd_sequencer
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             abort,
    output logic             ld_en,
    output logic             updwn,
    output logic             en,
    output logic [WIDTH-1:0] datain,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    seq_state_e       state_reg, state_next;
    logic [LEN_W-1:0] rem_reg, rem_next;
    logic             ld_en_reg, ld_en_next;
    logic             en_reg, en_next;
    logic             updwn_reg, updwn_next;
    logic [WIDTH-1:0] datain_reg, datain_next;
    logic             done_reg, done_next;
    logic             aborted_reg, aborted_next;
    cmd_op_e          op;

    assign op = cmd_op_e'(cmd_op);

    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        ld_en_next   = 1'b0;
        en_next      = 1'b0;
        updwn_next   = updwn_reg;
        datain_next  = datain_reg;
        done_next    = 1'b0;
        aborted_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (cmd_valid) begin
                    rem_next = cmd_len;
                    case (op)
                        OP_LOAD: begin
                            state_next  = S_LOAD;
                            ld_en_next  = 1'b1;
                            datain_next = cmd_arg;
                        end
                        OP_UP, OP_DOWN: begin
                            state_next = S_RUN;
                            updwn_next = (op == OP_UP);
                            en_next    = (cmd_len != '0);
                            done_next  = (cmd_len == '0);
                        end
                        default: begin
                            state_next = S_HOLD;
                            done_next  = (cmd_len == '0);
                        end
                    endcase
                end
            end
            S_LOAD: begin
                state_next   = S_IDLE;
                aborted_next = abort;
                done_next    = ~abort;
            end
            default: begin
                // rem==0 only for a zero-length command already signalling done,
                // so abort can no longer affect it.
                if (rem_reg == '0) begin
                    state_next = S_IDLE;
                end else if (abort) begin
                    state_next   = S_IDLE;
                    aborted_next = 1'b1;
                end else if (rem_reg == LEN_W'(1)) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    rem_next = rem_reg - LEN_W'(1);
                    en_next  = (state_reg == S_RUN);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_IDLE;
            rem_reg     <= '0;
            ld_en_reg   <= 1'b0;
            en_reg      <= 1'b0;
            updwn_reg   <= 1'b0;
            datain_reg  <= '0;
            done_reg    <= 1'b0;
            aborted_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            rem_reg     <= rem_next;
            ld_en_reg   <= ld_en_next;
            en_reg      <= en_next;
            updwn_reg   <= updwn_next;
            datain_reg  <= datain_next;
            done_reg    <= done_next;
            aborted_reg <= aborted_next;
        end
    end

    assign cmd_ready = (state_reg == S_IDLE);
    assign busy      = (state_reg != S_IDLE);
    assign ld_en     = ld_en_reg;
    assign en        = en_reg;
    assign updwn     = updwn_reg;
    assign datain    = datain_reg;
    assign done      = done_reg;
    assign aborted   = aborted_reg;

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: table of commands, per-cycle expected outputs
// queued on issue and compared as cycles elapse, plus a stand-in 8-bit counter.
`timescale 1ns/1ps
module tb_counter_cmd_sequencer;
    import counter_seq_pkg::*;

    localparam int WIDTH = 8;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'd0;
    logic [WIDTH-1:0] cmd_arg = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             abort = 1'b0;
    logic             ld_en, updwn, en, busy, done, aborted;
    logic [WIDTH-1:0] datain;

    counter_cmd_sequencer #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_len(cmd_len), .abort(abort),
        .ld_en(ld_en), .updwn(updwn), .en(en), .datain(datain),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream counter, driven by the sequencer outputs.
    logic [7:0] cnt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= 8'h00;
        else if (ld_en) cnt <= datain;
        else if (en) cnt <= updwn ? cnt + 8'h01 : cnt - 8'h01;
    end

    typedef struct packed {
        logic       ld_en;
        logic       en;
        logic       updwn;
        logic [7:0] datain;
        logic       busy;
        logic       done;
        logic       aborted;
        logic       ready;
    } out_t;

    typedef struct {
        logic [1:0] op;
        logic [7:0] arg;
        logic [7:0] len;
        int         abort_at;  // cycle index relative to accept (0 = accept cycle), -1 = none
        int         gap;       // idle cycles afterwards, 0 = back-to-back
        logic [7:0] exp_cnt;
    } vec_t;

    out_t       exp_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    logic       exp_updwn = 1'b0;
    logic [7:0] exp_datain = 8'h00;
    vec_t       vecs[15];

    function automatic out_t actual();
        out_t a;
        a = '{ld_en: ld_en, en: en, updwn: updwn, datain: datain, busy: busy,
              done: done, aborted: aborted, ready: cmd_ready};
        return a;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", nm, act, req);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t idle_rec(input logic dn, input logic ab);
        out_t r;
        r = '{ld_en: 1'b0, en: 1'b0, updwn: exp_updwn, datain: exp_datain, busy: 1'b0,
              done: dn, aborted: ab, ready: 1'b1};
        return r;
    endfunction

    task automatic run_cmd(input vec_t v, input int idx);
        bit   is_zero, do_abort;
        int   last_busy, nact, k, total;
        out_t r, a;
        is_zero   = (v.op != 2'(OP_LOAD)) && (v.len == 8'd0);
        last_busy = (v.op == 2'(OP_LOAD)) ? 1 : int'(v.len);
        do_abort  = !is_zero && v.abort_at >= 1 && v.abort_at <= last_busy;
        nact      = do_abort ? v.abort_at : last_busy;
        if (v.op == 2'(OP_UP) || v.op == 2'(OP_DOWN)) exp_updwn = (v.op == 2'(OP_UP));
        if (v.op == 2'(OP_LOAD)) exp_datain = v.arg;
        if (is_zero) begin
            r = idle_rec(1'b1, 1'b0);
            r.busy = 1'b1;
            r.ready = 1'b0;
            exp_q.push_back(r);
            exp_q.push_back(idle_rec(1'b0, 1'b0));
        end else begin
            for (int i = 1; i <= nact; i++) begin
                r = idle_rec(1'b0, 1'b0);
                r.ld_en = (v.op == 2'(OP_LOAD));
                r.en    = (v.op == 2'(OP_UP) || v.op == 2'(OP_DOWN));
                r.busy  = 1'b1;
                r.ready = 1'b0;
                exp_q.push_back(r);
            end
            exp_q.push_back(idle_rec(!do_abort, do_abort));
        end
        // accept cycle
        cmd_valid = 1'b1;
        cmd_op    = v.op;
        cmd_arg   = v.arg;
        cmd_len   = v.len;
        abort     = (v.abort_at == 0);
        total     = exp_q.size();
        for (k = 1; k <= total; k++) begin
            step();
            // keep a junk command offered while busy; it must not be taken
            cmd_valid = (k != total);
            cmd_op    = 2'($urandom_range(0, 3));
            cmd_arg   = 8'($urandom);
            cmd_len   = 8'($urandom);
            abort     = (k == v.abort_at);
            r = exp_q.pop_front();
            a = actual();
            chk($sformatf("cmd%0d_cyc%0d", idx, k), 16'(a), 16'(r));
        end
        cmd_valid = 1'b0;
        abort     = 1'b0;
        for (int g = 0; g < v.gap; g++) begin
            abort = 1'b1;  // abort while idle must be ignored
            step();
            abort = 1'b0;
            chk($sformatf("cmd%0d_idle%0d", idx, g), 16'(actual()), 16'(idle_rec(1'b0, 1'b0)));
        end
        chk($sformatf("cmd%0d_count", idx), 16'(cnt), 16'(v.exp_cnt));
        $display("cmd %0d op=%0d arg=%h len=%0d abort_at=%0d -> count=%h (want %h)",
                 idx, v.op, v.arg, v.len, v.abort_at, cnt, v.exp_cnt);
    endtask

    initial begin
        vecs[0]  = '{2'(OP_LOAD), 8'hA5,  8'd0, -1, 1, 8'hA5};
        vecs[1]  = '{2'(OP_LOAD), 8'hFD,  8'd0, -1, 0, 8'hFD};
        vecs[2]  = '{2'(OP_UP),   8'h00,  8'd3, -1, 1, 8'h00};
        vecs[3]  = '{2'(OP_DOWN), 8'h00,  8'd0, -1, 1, 8'h00};
        vecs[4]  = '{2'(OP_UP),   8'h00, 8'd255, 10, 1, 8'h0A};
        vecs[5]  = '{2'(OP_UP),   8'h00,  8'd2, -1, 0, 8'h0C};
        vecs[6]  = '{2'(OP_DOWN), 8'h00,  8'd2, -1, 0, 8'h0A};
        vecs[7]  = '{2'(OP_HOLD), 8'h00,  8'd4, -1, 1, 8'h0A};
        vecs[8]  = '{2'(OP_UP),   8'h00,  8'd4,  0, 1, 8'h0E};
        vecs[9]  = '{2'(OP_LOAD), 8'h3C,  8'd9,  1, 1, 8'h3C};
        vecs[10] = '{2'(OP_HOLD), 8'h00,  8'd5,  2, 1, 8'h3C};
        vecs[11] = '{2'(OP_DOWN), 8'h00,  8'd3,  4, 0, 8'h39};
        vecs[12] = '{2'(OP_UP),   8'h00,  8'd1, -1, 0, 8'h3A};
        vecs[13] = '{2'(OP_HOLD), 8'h00,  8'd0, -1, 0, 8'h3A};
        vecs[14] = '{2'(OP_DOWN), 8'h00,  8'd1,  1, 1, 8'h39};

        // reset state
        #2;
        chk("reset_outputs", 16'(actual()), 16'(idle_rec(1'b0, 1'b0)));
        step();
        rst = 1'b0;
        step();
        chk("post_reset_idle", 16'(actual()), 16'(idle_rec(1'b0, 1'b0)));

        for (int i = 0; i < 15; i++) run_cmd(vecs[i], i);

        // reset in the middle of a long UP run
        cmd_valid = 1'b1;
        cmd_op    = 2'(OP_UP);
        cmd_len   = 8'd20;
        step();
        cmd_valid = 1'b0;
        chk("midrun_active", {15'd0, en}, 16'd1);
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        exp_updwn  = 1'b0;
        exp_datain = 8'h00;
        chk("midrun_async_clear", 16'(actual()), 16'(idle_rec(1'b0, 1'b0)));
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("after_reset_%0d", i), 16'(actual()), 16'(idle_rec(1'b0, 1'b0)));
        end
        $display("reset mid-run: count=%h", cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
